// File: rtl/regfile_sb.sv
// regfile_sb: parameterized register file with an issue/write-back scoreboard,
// optional write-to-read forwarding and a sequential soft-clear engine.

// One read lane: address-0 masking, forwarding mux and pending masking.
module regfile_sb_rd #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            rst,
  input  logic            fwd_en,   // write-back live this cycle and block IDLE
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] stored,
  input  logic            stored_pend,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            pend
);
  logic fwd;

  // Forward only a real write to a non-zero address; reset forces zeros out.
  always_comb begin
    fwd  = (BYPASS != 0) && fwd_en && (wb_addr == addr) && (addr != '0);
    data = stored;
    pend = stored_pend;
    if (rst || addr == '0) begin
      data = '0;
      pend = 1'b0;
    end else if (fwd) begin
      data = wb_data;
      pend = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_pending,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                clr_busy
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           pend_q, pend_d;
  logic [0:0]                state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic                      idle;

  assign idle     = (state_q == ST_IDLE);
  assign clr_busy = (state_q == ST_CLEAR);

  // Next-state: writes/issues only in IDLE; CLEAR walks one register per edge.
  always_comb begin
    regs_d  = regs_q;
    pend_d  = pend_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (idle) begin
      if (wb_en && wb_addr != '0) begin
        regs_d[wb_addr] = wb_data;
        pend_d[wb_addr] = 1'b0;
      end
      // Issue after write-back so a same-address collision stays pending.
      if (iss_en && iss_addr != '0)
        pend_d[iss_addr] = 1'b1;
      if (clr_req) begin
        state_d = ST_CLEAR;
        cnt_d   = AW'(1);
      end
    end else begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
      if (cnt_q == AW'(NREG - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= '0;
      pend_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic fwd_en;
  assign fwd_en = wb_en && idle && !rst;

  // One read lane per port.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rs_addr[i*AW +: AW];
    regfile_sb_rd #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .rst         (rst),
      .fwd_en      (fwd_en),
      .addr        (a),
      .stored      (regs_q[a]),
      .stored_pend (pend_q[a]),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .data        (rs_data[i*XLEN +: XLEN]),
      .pend        (rs_pending[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and 4-port/64-bit builds.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default build: XLEN=32 NREG=32 NRD=2 BYPASS=1
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_pending;
  logic        wb_en, iss_en, clr_req, clr_busy;
  logic [4:0]  wb_addr, iss_addr;
  logic [31:0] wb_data;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_pending(rs_pending),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  // No-bypass build: XLEN=16 NREG=8 NRD=2
  logic [5:0]  b_rs_addr;
  logic [31:0] b_rs_data;
  logic [1:0]  b_rs_pending;
  logic        b_wb_en, b_iss_en, b_clr_req, b_clr_busy;
  logic [2:0]  b_wb_addr, b_iss_addr;
  logic [15:0] b_wb_data;

  regfile_sb #(.XLEN(16), .NREG(8), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_pending(b_rs_pending),
    .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data), .iss_en(b_iss_en),
    .iss_addr(b_iss_addr), .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  // Wide build: XLEN=64 NREG=16 NRD=4
  logic [15:0]  w_rs_addr;
  logic [255:0] w_rs_data;
  logic [3:0]   w_rs_pending;
  logic         w_wb_en, w_iss_en, w_clr_req, w_clr_busy;
  logic [3:0]   w_wb_addr, w_iss_addr;
  logic [63:0]  w_wb_data;

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(4), .BYPASS(1)) dut_w (
    .clk(clk), .rst(rst), .rs_addr(w_rs_addr), .rs_data(w_rs_data), .rs_pending(w_rs_pending),
    .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data), .iss_en(w_iss_en),
    .iss_addr(w_iss_addr), .clr_req(w_clr_req), .clr_busy(w_clr_busy)
  );

  task automatic test_reset();
    rst = 1'b1;
    rs_addr = {5'd5, 5'd5}; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd5; clr_req = 1'b0;
    b_rs_addr = '0; b_wb_en = 0; b_wb_addr = '0; b_wb_data = '0; b_iss_en = 0; b_iss_addr = '0; b_clr_req = 0;
    w_rs_addr = '0; w_wb_en = 0; w_wb_addr = '0; w_wb_data = '0; w_iss_en = 0; w_iss_addr = '0; w_clr_req = 0;
    #3;
    checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL rst_rd_zero got %h exp 0", rs_data); end
    checks++; if (rs_pending !== 2'b00) begin errors++; $display("FAIL rst_pend_zero got %b exp 00", rs_pending); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", clr_busy); end
    @(negedge clk);
    wb_en = 1'b0; iss_en = 1'b0; rst = 1'b0;
    #1;
    checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL rst_release got %h exp 0", rs_data); end
    checks++; if (rs_pending !== 2'b00) begin errors++; $display("FAIL rst_release_pend got %b exp 00", rs_pending); end
  endtask

  task automatic test_write();
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; rs_addr = {5'd0, 5'd5};
    @(negedge clk);
    wb_en = 1'b0; #1;
    checks++; if (rs_data[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_x5 got %h exp deadbeef", rs_data[31:0]); end
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs_addr = {5'd0, 5'd0}; #1;
    checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL x0_same_cycle got %h exp 0", rs_data); end
    @(negedge clk);
    wb_en = 1'b0; #1;
    checks++; if (rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL x0_after got %h exp 0", rs_data[31:0]); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1111_1111; rs_addr = {5'd7, 5'd0};
    @(negedge clk);
    wb_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd7;
    @(negedge clk);
    iss_en = 1'b0; #1;
    checks++; if (rs_pending[1] !== 1'b1) begin errors++; $display("FAIL byp_pend_before got %b exp 1", rs_pending[1]); end
    checks++; if (rs_data[63:32] !== 32'h1111_1111) begin errors++; $display("FAIL byp_old got %h exp 11111111", rs_data[63:32]); end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5; #1;
    checks++; if (rs_data[63:32] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_data got %h exp a5a5a5a5", rs_data[63:32]); end
    checks++; if (rs_pending[1] !== 1'b0) begin errors++; $display("FAIL byp_pend got %b exp 0", rs_pending[1]); end
    checks++; if (rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL byp_port0_x0 got %h exp 0", rs_data[31:0]); end
    @(negedge clk);
    wb_en = 1'b0; #1;
    checks++; if (rs_data[63:32] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_stored got %h exp a5a5a5a5", rs_data[63:32]); end
    checks++; if (rs_pending[1] !== 1'b0) begin errors++; $display("FAIL byp_pend_after got %b exp 0", rs_pending[1]); end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    b_wb_en = 1'b1; b_wb_addr = 3'd3; b_wb_data = 16'h0011; b_rs_addr = {3'd0, 3'd3};
    @(negedge clk);
    b_wb_data = 16'h2222; #1;
    checks++; if (b_rs_data[15:0] !== 16'h0011) begin errors++; $display("FAIL nobyp_old got %h exp 0011", b_rs_data[15:0]); end
    @(negedge clk);
    b_wb_en = 1'b0; #1;
    checks++; if (b_rs_data[15:0] !== 16'h2222) begin errors++; $display("FAIL nobyp_new got %h exp 2222", b_rs_data[15:0]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    rs_addr = {5'd0, 5'd3}; iss_en = 1'b1; iss_addr = 5'd3;
    @(negedge clk);
    iss_en = 1'b0; #1;
    checks++; if (rs_pending[0] !== 1'b1) begin errors++; $display("FAIL iss_set got %b exp 1", rs_pending[0]); end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    @(negedge clk);
    wb_en = 1'b0; #1;
    checks++; if (rs_pending[0] !== 1'b0) begin errors++; $display("FAIL wb_clr got %b exp 0", rs_pending[0]); end
    iss_en = 1'b1; iss_addr = 5'd3; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h44;
    @(negedge clk);
    iss_en = 1'b0; wb_en = 1'b0; #1;
    checks++; if (rs_pending[0] !== 1'b1) begin errors++; $display("FAIL iss_wb_pend got %b exp 1", rs_pending[0]); end
    checks++; if (rs_data[31:0] !== 32'h44) begin errors++; $display("FAIL iss_wb_data got %h exp 44", rs_data[31:0]); end
    iss_en = 1'b1; iss_addr = 5'd3;
    @(negedge clk);
    @(negedge clk);
    iss_en = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    @(negedge clk);
    wb_en = 1'b0; #1;
    checks++; if (rs_pending[0] !== 1'b0) begin errors++; $display("FAIL repeat_iss_clr got %b exp 0", rs_pending[0]); end
    iss_en = 1'b1; iss_addr = 5'd0; rs_addr = {5'd0, 5'd0};
    @(negedge clk);
    iss_en = 1'b0; #1;
    checks++; if (rs_pending !== 2'b00) begin errors++; $display("FAIL iss_x0 got %b exp 00", rs_pending); end
  endtask

  task automatic test_clear();
    int busy = 0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wb_en = 1'b1; wb_addr = 5'(i); wb_data = 32'h1000_0000 | i;
    end
    @(negedge clk);
    wb_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    iss_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!clr_busy) break;
      busy++;
      if (busy == 5) begin
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hBAD0_BAD0;
        iss_en = 1'b1; iss_addr = 5'd4; clr_req = 1'b1; rs_addr = {5'd31, 5'd1}; #1;
        checks++; if (rs_data[31:0] !== 32'h0) begin errors++; $display("FAIL clr_no_bypass got %h exp 0", rs_data[31:0]); end
        checks++; if (rs_data[63:32] !== 32'h1000_001F) begin errors++; $display("FAIL clr_partial got %h exp 1000001f", rs_data[63:32]); end
      end else begin
        wb_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
      end
      @(negedge clk);
    end
    wb_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    checks++; if (busy !== 31) begin errors++; $display("FAIL clr_busy_cycles got %0d exp 31", busy); end
    for (int i = 0; i < 32; i++) begin
      rs_addr = {5'(31 - i), 5'(i)}; #1;
      checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL clr_zero x%0d got %h exp 0", i, rs_data); end
    end
    rs_addr = {5'd4, 5'd9}; #1;
    checks++; if (rs_pending !== 2'b00) begin errors++; $display("FAIL clr_pend got %b exp 00", rs_pending); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_done_idle got %b exp 0", clr_busy); end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'hCAFE_0031;
    @(negedge clk);
    wb_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rs_addr = {5'd31, 5'd31}; #1;
    checks++; if (rs_data[31:0] !== 32'hCAFE_0031) begin errors++; $display("FAIL pre_rst_data got %h exp cafe0031", rs_data[31:0]); end
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got %b exp 1", clr_busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", clr_busy); end
    checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", rs_data); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rel_busy got %b exp 0", clr_busy); end
    checks++; if (rs_data !== 64'h0) begin errors++; $display("FAIL rel_data got %h exp 0", rs_data); end
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    @(negedge clk);
    wb_en = 1'b0; rs_addr = {5'd0, 5'd6}; #1;
    checks++; if (rs_data[31:0] !== 32'h66) begin errors++; $display("FAIL idle_after_rel got %h exp 66", rs_data[31:0]); end
  endtask

  task automatic test_wide();
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      w_wb_en = 1'b1; w_wb_addr = 4'(i); w_wb_data = 64'hABCD_0000_0000_0000 + 64'(i);
    end
    @(negedge clk);
    w_wb_en = 1'b0; w_rs_addr = {4'd2, 4'd9, 4'd15, 4'd1}; #1;
    checks++; if (w_rs_data[0 +: 64] !== 64'hABCD_0000_0000_0001) begin errors++; $display("FAIL wide_p0 got %h exp abcd000000000001", w_rs_data[0 +: 64]); end
    checks++; if (w_rs_data[64 +: 64] !== 64'hABCD_0000_0000_000F) begin errors++; $display("FAIL wide_p1 got %h exp abcd00000000000f", w_rs_data[64 +: 64]); end
    checks++; if (w_rs_data[128 +: 64] !== 64'hABCD_0000_0000_0009) begin errors++; $display("FAIL wide_p2 got %h exp abcd000000000009", w_rs_data[128 +: 64]); end
    checks++; if (w_rs_data[192 +: 64] !== 64'hABCD_0000_0000_0002) begin errors++; $display("FAIL wide_p3 got %h exp abcd000000000002", w_rs_data[192 +: 64]); end
    w_rs_addr = 16'h0; #1;
    checks++; if (w_rs_data !== 256'h0) begin errors++; $display("FAIL wide_x0 got %h exp 0", w_rs_data); end
    checks++; if (w_rs_pending !== 4'h0) begin errors++; $display("FAIL wide_pend got %b exp 0000", w_rs_pending); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_no_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
